reset_sequencer: RTL and testbench

Consumes the raw, asynchronous active-low reset and PLL lock from the clock/reset front end and distributes ordered, synchronized resets to the design's sub-domains (e.g. memory, CPU, peripherals). Assertion is asynchronous. Release is synchronous, delayed, and staged, with a soft-reset request/acknowledge handshake for software- or debugger-initiated resets. It sits directly between the clock generator and every reset-consuming block.

---
 rtl/reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// =============================================================================
// reset_sequencer: async-assert, staged sync-release resets with soft-reset
// handshake; RSTSEQ_BRAM_WAIT_EN stretches the first HOLD to 4096 cycles. Rev 1.0
// =============================================================================
module reset_sequencer #(
   parameter int STAGES      = 3,
   parameter int SYNC_DEPTH  = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              lock,
   input  logic              sw_req,
   output logic [STAGES-1:0] stage_rstn,
   output logic              ready,
   output logic              sw_ack
);

`ifdef RSTSEQ_BRAM_WAIT_EN
   localparam int LONG_HOLD = 4096;
   localparam int HOLD_MAX  = (LONG_HOLD > HOLD_CYCLES) ? LONG_HOLD : HOLD_CYCLES;
`else
   localparam int HOLD_MAX  = HOLD_CYCLES;
`endif
   localparam int MAX_TC = ((HOLD_MAX > GAP_CYCLES) ? HOLD_MAX : GAP_CYCLES) - 1;
   localparam int CNT_W  = $clog2(MAX_TC) + 1;

   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

   localparam logic [1:0] S_ASSERT  = 2'd0;
   localparam logic [1:0] S_HOLD    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;
   localparam logic [1:0] S_RUN     = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  pending_q, pending_d;
   logic [SYNC_DEPTH-1:0] rst_chain_q, rst_chain_d;
   logic [SYNC_DEPTH-1:0] lock_chain_q, lock_chain_d;
   logic [STAGES-1:0]     stage_q, stage_d;
   logic                  ready_q, ready_d;
   logic                  sw_ack_q, sw_ack_d;

   logic                  rst_sync, lock_sync;
   logic [CNT_W-1:0]      hold_tc;
   logic                  hold_done, gap_done, last_release;
   logic [STAGES-1:0]     stage_shift;

   assign rst_chain_d  = {rst_chain_q[SYNC_DEPTH-2:0], 1'b1};
   assign lock_chain_d = {lock_chain_q[SYNC_DEPTH-2:0], lock};
   assign rst_sync     = rst_chain_q[SYNC_DEPTH-1];
   assign lock_sync    = lock_chain_q[SYNC_DEPTH-1];

`ifdef RSTSEQ_BRAM_WAIT_EN
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_HOLD - 1);
   logic first_done_q, first_done_d;
   assign hold_tc = first_done_q ? HOLD_TC : LONG_TC;
`else
   assign hold_tc = HOLD_TC;
`endif

   assign hold_done    = (cnt_q == hold_tc);
   assign gap_done     = (cnt_q == GAP_TC);
   assign stage_shift  = (stage_q << 1) | STAGES'(1);
   assign last_release = &stage_shift;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= S_ASSERT;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         rst_chain_q  <= '0;
         lock_chain_q <= '0;
         stage_q      <= '0;
         ready_q      <= 1'b0;
         sw_ack_q     <= 1'b0;
`ifdef RSTSEQ_BRAM_WAIT_EN
         first_done_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         rst_chain_q  <= rst_chain_d;
         lock_chain_q <= lock_chain_d;
         stage_q      <= stage_d;
         ready_q      <= ready_d;
         sw_ack_q     <= sw_ack_d;
`ifdef RSTSEQ_BRAM_WAIT_EN
         first_done_q <= first_done_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
`ifdef RSTSEQ_BRAM_WAIT_EN
      first_done_d = first_done_q;
`endif
      case (state_q)
         S_ASSERT: begin
            if (rst_sync && lock_sync) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         end
         S_HOLD: begin
            if (hold_done) begin
               state_d = (STAGES == 1) ? S_RUN : S_RELEASE;
               cnt_d   = '0;
`ifdef RSTSEQ_BRAM_WAIT_EN
               first_done_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            if (gap_done) begin
               cnt_d = '0;
               if (last_release) state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (sw_req) begin
               state_d   = S_HOLD;
               cnt_d     = '0;
               pending_d = 1'b1;
            end
         end
      endcase
      if (state_d == S_RUN && state_q != S_RUN) pending_d = 1'b0;
      // Lock loss overrides everything but still records a same-cycle soft request.
      if (!lock_sync && state_q != S_ASSERT) begin
         state_d   = S_ASSERT;
         cnt_d     = '0;
         pending_d = pending_q | ((state_q == S_RUN) & sw_req);
      end
   end

   always_comb begin
      stage_d = stage_q;
      if (state_q == S_HOLD && hold_done)      stage_d = STAGES'(1);
      if (state_q == S_RELEASE && gap_done)    stage_d = stage_shift;
      if (state_d == S_ASSERT || state_d == S_HOLD) stage_d = '0;
      ready_d  = (state_d == S_RUN);
      sw_ack_d = (state_d == S_RUN) && (state_q != S_RUN) && pending_q;
   end

   assign stage_rstn = stage_q;
   assign ready      = ready_q;
   assign sw_ack     = sw_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// =============================================================================
// tb_reset_sequencer: directed bench for reset_sequencer at default parameters.
// Rev 1.0
// =============================================================================
module tb_reset_sequencer;

`ifdef RSTSEQ_BRAM_WAIT_EN
   localparam int FIRST_HOLD = 4096;
`else
   localparam int FIRST_HOLD = 16;
`endif
   localparam int HOLD = 16;
   localparam int GAP  = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       lock = 1'b1;
   logic       sw_req = 1'b0;
   logic [2:0] stage_rstn;
   logic       ready;
   logic       sw_ack;

   int vectors = 0;
   int errors  = 0;

   reset_sequencer dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .lock       (lock),
      .sw_req     (sw_req),
      .stage_rstn (stage_rstn),
      .ready      (ready),
      .sw_ack     (sw_ack)
   );

   always #5 CLK = ~CLK;

   // Expected stage vector n edges after HOLD entry.
   function automatic logic [2:0] exp_stage(input int n, input int hold_len);
      logic [2:0] r;
      for (int k = 0; k < 3; k++) r[k] = (n >= hold_len + k * GAP);
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
   endtask

   // Hard reset sequence; sw_at >= 0 pulses sw_req so it is sampled on that edge.
   task automatic hard_seq(input int sw_at, input string tag);
      logic [2:0] es;
      int         last;
      last = 2 + FIRST_HOLD + 2 * GAP + 3;
      apply_reset();
      for (int e = 0; e <= last; e++) begin
         tick();
         if (e == sw_at) sw_req = 1'b0;
         es = (e < 2) ? 3'b000 : exp_stage(e - 2, FIRST_HOLD);
         vectors++;
         if (stage_rstn !== es || ready !== (es == 3'b111) || sw_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s edge %0d: stage=%b ready=%b ack=%b, want stage=%b ready=%b ack=0",
                     tag, e, stage_rstn, ready, sw_ack, es, es == 3'b111);
         end
         if (e + 1 == sw_at) sw_req = 1'b1;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      lock  = 1'b1;
      repeat (3) tick();
      vectors++;
      if (stage_rstn !== 3'b000 || ready !== 1'b0 || sw_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: stage=%b ready=%b ack=%b, want 000 0 0",
                  stage_rstn, ready, sw_ack);
      end
      hard_seq(-1, "hard_release");
   endtask

   task automatic test_sw_reset();
      logic [2:0] es;
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      for (int n = 0; n <= HOLD + 2 * GAP + 3; n++) begin
         if (n > 0) tick();
         es = exp_stage(n, HOLD);
         vectors++;
         if (stage_rstn !== es || ready !== (es == 3'b111) || sw_ack !== (n == HOLD + 2 * GAP)) begin
            errors++;
            $display("FAIL sw_reset +%0d: stage=%b ready=%b ack=%b, want stage=%b ready=%b ack=%b",
                     n, stage_rstn, ready, sw_ack, es, es == 3'b111, n == HOLD + 2 * GAP);
         end
      end
   endtask

   task automatic test_lock_loss();
      logic [2:0] es;
      int s0, drop, loss, rehold;
      s0     = 2 + FIRST_HOLD;
      drop   = s0 + 1;
      loss   = drop + 3;
      rehold = loss + 1;
      apply_reset();
      for (int e = 0; e <= rehold + HOLD + 2 * GAP + 3; e++) begin
         tick();
         if (e < 2)           es = 3'b000;
         else if (e < loss)   es = exp_stage(e - 2, FIRST_HOLD);
         else if (e < rehold) es = 3'b000;
         else                 es = exp_stage(e - rehold, HOLD);
         vectors++;
         if (stage_rstn !== es || ready !== (es == 3'b111) || sw_ack !== 1'b0) begin
            errors++;
            $display("FAIL lock_loss edge %0d: stage=%b ready=%b ack=%b, want stage=%b ready=%b ack=0",
                     e, stage_rstn, ready, sw_ack, es, es == 3'b111);
         end
         if (e == drop)     lock = 1'b0;
         if (e == drop + 1) lock = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      @(posedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      vectors++;
      if (stage_rstn !== 3'b000 || ready !== 1'b0 || sw_ack !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: stage=%b ready=%b ack=%b, want 000 0 0",
                  stage_rstn, ready, sw_ack);
      end
      tick();
      vectors++;
      if (stage_rstn !== 3'b000 || ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_held: stage=%b ready=%b, want 000 0", stage_rstn, ready);
      end
   endtask

   task automatic test_sw_in_hold();
      hard_seq(5, "sw_in_hold");
   endtask

   initial begin
      test_reset();
      test_sw_reset();
      test_lock_loss();
      test_async_reset();
      test_sw_in_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
